// File: rtl/dino_pkg.sv
// ----------------------------------------------------------------------------
// dino_pkg
// Shared constants for the runner game datapath: screen geometry, cactus
// sprite type encodings, obstacle slot count and the screen-X word width.
// No ports; imported by obstacle_slot and obstacle_spawner.
// ----------------------------------------------------------------------------
package dino_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int GROUND_Y = 245;

    // Cactus sprite selectors; code 3 is drawn as CACT_1 by the compositor.
    localparam logic [1:0] CACT_1 = 2'd0;
    localparam logic [1:0] CACT_2 = 2'd1;
    localparam logic [1:0] CACT_3 = 2'd2;

    localparam int NUM_SLOTS = 3;

    // Signed screen-X width; holds -64..SCREEN_W without wrapping.
    localparam int X_W = 12;

endpackage

// File: rtl/obstacle_slot.sv
// ----------------------------------------------------------------------------
// obstacle_slot
// One cactus slot: live flag, sprite type and signed screen X of the left edge.
// Ports:
//   clk, reset         pixel clock, async active-high reset
//   i_move             one-cycle strobe: shift left by i_speed, retire if off-screen
//   i_speed            pixels to move on i_move
//   i_load             one-cycle strobe: occupy slot at the spawn column
//   i_type             sprite type captured on i_load
//   o_active/o_type/o_x registered slot state
// i_move and i_load never coincide (different FSM phases).
// ----------------------------------------------------------------------------
module obstacle_slot
    import dino_pkg::*;
#(
    parameter int SPAWN_X  = 640,
    parameter int CACTUS_W = 27
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_move,
    input  logic [3:0]            i_speed,
    input  logic                  i_load,
    input  logic [1:0]            i_type,
    output logic                  o_active,
    output logic [1:0]            o_type,
    output logic signed [X_W-1:0] o_x
);

    localparam logic signed [X_W-1:0] L_SPAWN_X  = X_W'(SPAWN_X);
    localparam logic signed [X_W-1:0] L_RETIRE_X = X_W'(0 - CACTUS_W);

    logic                  r_active;
    logic [1:0]            r_type;
    logic signed [X_W-1:0] r_x;
    logic signed [X_W-1:0] w_next_x;

    assign w_next_x = r_x - $signed({{(X_W-4){1'b0}}, i_speed});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_type   <= 2'd0;
            r_x      <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_type   <= i_type;
            r_x      <= L_SPAWN_X;
        end else if (i_move && r_active) begin
            r_x <= w_next_x;
            // Once the whole sprite is past the left border the slot is free;
            // the leftover X is never drawn.
            if (w_next_x <= L_RETIRE_X) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_active = r_active;
    assign o_type   = r_type;
    assign o_x      = r_x;

endmodule

// File: rtl/obstacle_spawner.sv
// ----------------------------------------------------------------------------
// obstacle_spawner
// Frame-rate cactus scheduler. Once per frame it moves live slots left,
// retires off-screen ones, spawns a cactus at the right edge after a random
// gap, and ramps the scroll speed.
// Ports:
//   clk          25 MHz pixel clock
//   reset        async active-high full restart
//   frame_tick   one-cycle pulse at start of vertical blank
//   halt         collision latched: frame_tick ignored while high
//   random       rng bits, [1:0] sprite type, [4:2] gap length (spawn only)
//   slot_active  per-slot live flags
//   slot_type    {type2,type1,type0}
//   slot_x       {x2,x1,x0}, 12-bit signed left-edge X
//   speed        current px/frame
//   spawn_pulse  one-cycle pulse when a slot is loaded
//   state_dbg    current FSM state
// Timing: frame_tick is a bare strobe (no handshake). It is honoured only in
// IDLE; a tick seen in MOVE/SPAWN is dropped. halt is sampled only in IDLE, so
// a running MOVE/SPAWN sequence always completes.
// ----------------------------------------------------------------------------
module obstacle_spawner
    import dino_pkg::*;
#(
    parameter int SPAWN_X    = 640,
    parameter int CACTUS_W   = 27,
    parameter int MIN_GAP    = 40,
    parameter int GAP_STEP   = 4,
    parameter int SPEED_INIT = 4,
    parameter int SPEED_MAX  = 10,
    parameter int SPEED_UP   = 600
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic                       halt,
    input  logic [4:0]                 random,
    output logic [NUM_SLOTS-1:0]       slot_active,
    output logic [2*NUM_SLOTS-1:0]     slot_type,
    output logic [X_W*NUM_SLOTS-1:0]   slot_x,
    output logic [3:0]                 speed,
    output logic                       spawn_pulse,
    output logic [1:0]                 state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MOVE  = 2'd1;
    localparam logic [1:0] S_SPAWN = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_gap;
    logic [9:0] r_ramp;
    logic [3:0] r_speed;
    logic       r_pulse;

    logic [NUM_SLOTS-1:0]  w_active;
    logic [NUM_SLOTS-1:0]  w_load;
    logic                  w_move;
    logic                  w_free_valid;
    logic [1:0]            w_free_idx;
    logic                  w_spawn_go;
    logic [7:0]            w_gap_reload;

    assign w_move       = (r_state == S_MOVE);
    assign w_gap_reload = 8'(MIN_GAP + int'(random[4:2]) * GAP_STEP);

    // Lowest-index free slot; scanning downward lets the lowest one win.
    always_comb begin
        w_free_valid = 1'b0;
        w_free_idx   = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!w_active[i]) begin
                w_free_valid = 1'b1;
                w_free_idx   = 2'(i);
            end
        end
    end

    // Slot flags here already reflect retirements done in MOVE.
    assign w_spawn_go = (r_state == S_SPAWN) && (r_gap == 8'd0) && w_free_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gap   <= 8'(MIN_GAP);
            r_ramp  <= '0;
            r_speed <= 4'(SPEED_INIT);
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_tick && !halt) begin
                        r_state <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    r_state <= S_SPAWN;
                    if (r_ramp == 10'(SPEED_UP - 1)) begin
                        r_ramp <= '0;
                        if (r_speed < 4'(SPEED_MAX)) begin
                            r_speed <= r_speed + 4'd1;
                        end
                    end else begin
                        r_ramp <= r_ramp + 10'd1;
                    end
                    if (r_gap != 8'd0) begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                S_SPAWN: begin
                    r_state <= S_IDLE;
                    // With no free slot the gap stays at zero and the spawn
                    // is retried on the next frame.
                    if (w_spawn_go) begin
                        r_gap   <= w_gap_reload;
                        r_pulse <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        logic signed [X_W-1:0] w_x;
        logic [1:0]            w_type;

        assign w_load[g] = w_spawn_go && (w_free_idx == 2'(g));

        obstacle_slot #(
            .SPAWN_X  (SPAWN_X),
            .CACTUS_W (CACTUS_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .i_move   (w_move),
            .i_speed  (r_speed),
            .i_load   (w_load[g]),
            .i_type   (random[1:0]),
            .o_active (w_active[g]),
            .o_type   (w_type),
            .o_x      (w_x)
        );

        assign slot_type[2*g +: 2]  = w_type;
        assign slot_x[X_W*g +: X_W] = w_x;
    end

    assign slot_active = w_active;
    assign speed       = r_speed;
    assign spawn_pulse = r_pulse;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_obstacle_spawner.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_obstacle_spawner
// Directed bench for obstacle_spawner. A reference model of the slot, gap and
// speed behaviour pushes expected output snapshots into exp_q when a frame is
// driven; they are popped and compared after the MOVE and SPAWN cycles.
// ----------------------------------------------------------------------------
module tb_obstacle_spawner;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic        halt;
    logic [4:0]  random;
    logic [2:0]  slot_active;
    logic [5:0]  slot_type;
    logic [35:0] slot_x;
    logic [3:0]  speed;
    logic        spawn_pulse;
    logic [1:0]  state_dbg;

    obstacle_spawner dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .halt        (halt),
        .random      (random),
        .slot_active (slot_active),
        .slot_type   (slot_type),
        .slot_x      (slot_x),
        .speed       (speed),
        .spawn_pulse (spawn_pulse),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    logic [49:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    logic [2:0]  m_act;
    logic [5:0]  m_type;
    logic [35:0] m_x;
    int          m_speed;
    int          m_ramp;
    int          m_gap;

    logic [2:0]  obs_move_active;
    logic        obs_pulse;

    // Snapshot packing; X of a dead slot is don't-care and is masked.
    function automatic logic [49:0] pack(input logic [2:0] a, input logic [5:0] t,
                                         input logic [35:0] x, input logic [3:0] s,
                                         input logic p);
        logic [35:0] xm;
        xm = x;
        for (int i = 0; i < 3; i++) begin
            if (!a[i]) xm[i*12 +: 12] = 12'd0;
        end
        return {a, t, xm, s, p};
    endfunction

    function automatic logic [49:0] model_snap(input logic p);
        return pack(m_act, m_type, m_x, 4'(m_speed), p);
    endfunction

    function automatic logic [49:0] dut_snap();
        return pack(slot_active, slot_type, slot_x, speed, spawn_pulse);
    endfunction

    task automatic model_reset();
        m_act   = 3'b000;
        m_type  = 6'd0;
        m_x     = 36'd0;
        m_speed = 4;
        m_ramp  = 0;
        m_gap   = 40;
    endtask

    task automatic model_frame(input logic [4:0] r, output logic [49:0] e_move,
                               output logic [49:0] e_spawn);
        logic signed [11:0] nx;
        int                 free_i;
        logic               spawned;
        // move phase
        for (int i = 0; i < 3; i++) begin
            if (m_act[i]) begin
                nx = $signed(m_x[i*12 +: 12]) - 12'(m_speed);
                m_x[i*12 +: 12] = nx;
                if (nx <= -27) m_act[i] = 1'b0;
            end
        end
        if (m_ramp == 599) begin
            m_ramp = 0;
            if (m_speed < 10) m_speed++;
        end else begin
            m_ramp++;
        end
        if (m_gap > 0) m_gap--;
        e_move = model_snap(1'b0);
        // spawn phase
        spawned = 1'b0;
        if (m_gap == 0) begin
            free_i = -1;
            for (int i = 2; i >= 0; i--) begin
                if (!m_act[i]) free_i = i;
            end
            if (free_i >= 0) begin
                m_act[free_i]          = 1'b1;
                m_x[free_i*12 +: 12]   = 12'd640;
                m_type[free_i*2 +: 2]  = r[1:0];
                m_gap                  = 40 + int'(r[4:2]) * 4;
                spawned                = 1'b1;
            end
        end
        e_spawn = model_snap(spawned);
    endtask

    task automatic check_val(input string tag, input logic [49:0] obs, input logic [49:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s expected queue empty", tag);
        end else begin
            check_val(tag, dut_snap(), exp_q.pop_front());
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change at negedge; outputs sampled at negedge.
    task automatic frame(input logic h, input logic [4:0] r);
        logic [49:0] em;
        logic [49:0] es;
        frame_tick = 1'b1;
        halt       = h;
        random     = r;
        if (!h) begin
            model_frame(r, em, es);
            exp_q.push_back(em);
            exp_q.push_back(es);
        end else begin
            exp_q.push_back(model_snap(1'b0));
        end
        @(posedge clk); @(negedge clk);
        frame_tick = 1'b0;
        if (!h) begin
            @(posedge clk); @(negedge clk);
            obs_move_active = slot_active;
            check_pop("move");
            @(posedge clk); @(negedge clk);
            obs_pulse = spawn_pulse;
            check_pop("spawn");
        end else begin
            obs_pulse = 1'b0;
            @(posedge clk); @(negedge clk);
            @(posedge clk); @(negedge clk);
            check_pop("halt_frozen");
        end
        @(posedge clk); @(negedge clk);
        check_val("pulse_clear", 50'(spawn_pulse), 50'(0));
        check_val("fsm_idle", 50'(state_dbg), 50'(0));
    endtask

    task automatic first_spawn_run();
        int f;
        int got;
        got = 0;
        for (f = 1; f <= 60 && got == 0; f++) begin
            frame(1'b0, 5'b00101);
            if (obs_pulse) got = f;
        end
        check_val("first_spawn_frame", 50'(got), 50'(40));
        check_val("spawn_x0", 50'(slot_x[11:0]), 50'(640));
        check_val("spawn_type0", 50'(slot_type[1:0]), 50'(1));
        check_val("spawn_active0", 50'(slot_active), 50'(3'b001));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        reset      = 1'b1;
        frame_tick = 1'b0;
        halt       = 1'b0;
        random     = 5'd0;
        obs_move_active = 3'b000;
        obs_pulse  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outputs", dut_snap(), {3'b0, 6'b0, 36'b0, 4'd4, 1'b0});
        check_val("reset_state", 50'(state_dbg), 50'(0));
        reset = 1'b0;
        @(negedge clk);

        // First spawn, gap reload 44 from random=00101
        first_spawn_run();

        // Ten frames at speed 4
        for (int i = 0; i < 10; i++) frame(1'b0, 5'b00101);
        check_val("x0_after_10", 50'(slot_x[11:0]), 50'(600));

        // Run until slot 0 retires (600 - 4k <= -27 -> k = 157); slots 1/2 fill
        // meanwhile and the blocked spawn lands in slot 0 on its retire frame.
        k = 0;
        obs_move_active = 3'b001;
        while (obs_move_active[0] && k < 200) begin
            frame(1'b0, 5'b00101);
            k++;
        end
        check_val("retire_frames", 50'(k), 50'(157));
        check_val("retire_respawn_slot0", 50'({obs_pulse, slot_active[0]}), 50'(2'b11));

        // random=0: minimum gap spawns
        for (int i = 0; i < 150; i++) frame(1'b0, 5'd0);

        // Freeze
        for (int i = 0; i < 50; i++) frame(1'b1, 5'($urandom_range(0, 31)));
        for (int i = 0; i < 20; i++) frame(1'b0, 5'($urandom_range(0, 31)));

        // Long run: speed ramps to the ceiling
        for (int i = 0; i < 4300; i++) frame(1'b0, 5'($urandom_range(0, 31)));
        check_val("speed_ceiling", 50'(speed), 50'(10));

        // Reset during SPAWN cycle
        frame_tick = 1'b1;
        halt       = 1'b0;
        random     = 5'b00101;
        @(posedge clk); @(negedge clk);
        frame_tick = 1'b0;
        @(posedge clk);
        #5;
        check_val("pre_reset_in_spawn", 50'(state_dbg), 50'(2));
        reset = 1'b1;
        #1;
        check_val("async_reset_outputs", dut_snap(), {3'b0, 6'b0, 36'b0, 4'd4, 1'b0});
        check_val("async_reset_state", 50'(state_dbg), 50'(0));
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        first_spawn_run();

        check_val("queue_drained", 50'(exp_q.size()), 50'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
